control_paralelo_serial: RTL

CONTROL_PARALELO_SERIAL -- requirements
Module: control_paralelo_serial

---
 rtl/paralelo_serial_pkg.sv | 16 +
 rtl/arbitro_rr.sv | 36 +++
 rtl/control_paralelo_serial.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared symbols and state encoding for the parallel-to-serial front-end control.
package paralelo_serial_pkg;

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin arbiter with burst limit; select is one-hot or 00 when nobody is valid.
module arbitro_rr #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       valid,
    input  logic             owner,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic [1:0]       select
);
    import paralelo_serial_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    logic w_keep;

    // Contention decision; a zero count means no burst is open, so the non-owner goes first
    always_comb begin
        select = 2'b00;
        w_keep = (burst_cnt != ZERO_CNT) && (burst_cnt < MAX_CNT);
        case (valid)
            2'b01:   select = 2'b01;
            2'b10:   select = 2'b10;
            2'b11: begin
                if (w_keep) begin
                    select = owner_onehot(owner);
                end else begin
                    select = owner_onehot(~owner);
                end
            end
            default: select = 2'b00;
        endcase
    end

endmodule

// File: rtl/control_paralelo_serial.sv
// Byte-level control in front of the parallel-serial converter: COM sync, two-requester arbitration.
// Optional macro SKP_INSERT_EN adds periodic SKP slots every SKP_INTERVAL active cycles.
module control_paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int SYNC_LEN     = 4,
    parameter int MAX_BURST    = 4,
    parameter int SKP_INTERVAL = 16
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       sync_done
);

    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int SYNC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO_CNT  = CNT_W'(0);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
    localparam logic [SYNC_W-1:0] SYNC_ONE  = SYNC_W'(1);
    localparam logic [SYNC_W-1:0] SYNC_ZERO = SYNC_W'(0);

    if (SYNC_LEN < 1 || MAX_BURST < 1 || SKP_INTERVAL < 2) begin : g_param_check
        $error("control_paralelo_serial: invalid parameter value");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SYNC_W-1:0] r_sync_cnt;
    logic [SYNC_W-1:0] w_sync_cnt_nxt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [CNT_W-1:0]  w_burst_nxt;
    logic              r_owner;
    logic              w_owner_nxt;
    logic [7:0]        r_data_out;
    logic [7:0]        w_data_nxt;
    logic              r_valid_out;
    logic              w_valid_nxt;
    logic [1:0]        r_grant;
    logic [1:0]        w_grant_nxt;
    logic [1:0]        w_select;
    logic [1:0]        w_ready;
    logic              w_taker;
    logic              w_skip_slot;

    arbitro_rr #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_arbitro_rr (
        .valid     ({req1_valid, req0_valid}),
        .owner     (r_owner),
        .burst_cnt (r_burst_cnt),
        .select    (w_select)
    );

`ifdef SKP_INSERT_EN
    localparam int SKP_W = $clog2(SKP_INTERVAL);
    localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_INTERVAL - 1);
    localparam logic [SKP_W-1:0] SKP_ONE  = SKP_W'(1);
    localparam logic [SKP_W-1:0] SKP_ZERO = SKP_W'(0);

    logic [SKP_W-1:0] r_skp_cnt;
    logic             r_skp_slot;

    // Active-cycle counter; it holds during the skip slot so slots recur every SKP_INTERVAL+1 cycles
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_skp_cnt  <= SKP_ZERO;
            r_skp_slot <= 1'b0;
        end else if (r_state == ST_ACTIVE && !r_skp_slot) begin
            if (r_skp_cnt == SKP_LAST) begin
                r_skp_cnt  <= SKP_ZERO;
                r_skp_slot <= 1'b1;
            end else begin
                r_skp_cnt  <= r_skp_cnt + SKP_ONE;
                r_skp_slot <= 1'b0;
            end
        end else begin
            r_skp_slot <= 1'b0;
        end
    end

    assign w_skip_slot = r_skp_slot;
`else
    assign w_skip_slot = 1'b0;
`endif

    // Next-state, arbitration bookkeeping and next output byte
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_burst_nxt    = r_burst_cnt;
        w_owner_nxt    = r_owner;
        w_data_nxt     = COM;
        w_valid_nxt    = 1'b0;
        w_grant_nxt    = 2'b00;
        w_ready        = 2'b00;
        w_taker        = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (r_sync_cnt == SYNC_LAST) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_sync_cnt_nxt = SYNC_ZERO;
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt + SYNC_ONE;
                end
            end
            ST_ACTIVE: begin
                if (w_skip_slot) begin
                    w_data_nxt = SKP;
                end else if (w_select != 2'b00) begin
                    w_ready     = w_select;
                    w_taker     = w_select[1];
                    w_data_nxt  = w_taker ? req1_data : req0_data;
                    w_valid_nxt = 1'b1;
                    w_grant_nxt = w_select;
                    if (w_taker == r_owner) begin
                        // Owner at the limit with no contender restarts its burst instead of saturating
                        if (r_burst_cnt >= MAX_CNT) begin
                            w_burst_nxt = ONE_CNT;
                        end else begin
                            w_burst_nxt = r_burst_cnt + ONE_CNT;
                        end
                    end else begin
                        w_owner_nxt = w_taker;
                        w_burst_nxt = ONE_CNT;
                    end
                end else begin
                    w_burst_nxt = ZERO_CNT;
                end
            end
            default: begin
                w_state_nxt    = ST_SYNC;
                w_sync_cnt_nxt = SYNC_ZERO;
            end
        endcase
    end

    // State register, counters and registered output byte
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SYNC;
            r_sync_cnt  <= SYNC_ZERO;
            r_burst_cnt <= ZERO_CNT;
            r_owner     <= 1'b1;
            r_data_out  <= COM;
            r_valid_out <= 1'b0;
            r_grant     <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_sync_cnt  <= w_sync_cnt_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_owner     <= w_owner_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_grant     <= w_grant_nxt;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign grant      = r_grant;
    assign sync_done  = (r_state == ST_ACTIVE);

endmodule
